// File: rtl/sorted_word_serializer_if.sv
// Handshake bundle between the bubble sorter, the serializer and the consumer.
//   din/din_vld/din_rdy            : packed 8-word frame in, valid/ready
//   dout/dout_vld/dout_rdy/dout_last : one word per beat out, valid/ready, end-of-frame
// Modports:
//   slave  - the serializer's view (takes frames, produces words)
//   master - the surrounding logic's view (offers frames, consumes words)
interface sorted_word_serializer_if #(
  parameter int BITWIDTH = 3
);
  logic [8*BITWIDTH-1:0] din;
  logic                  din_vld;
  logic                  din_rdy;
  logic [BITWIDTH-1:0]   dout;
  logic                  dout_vld;
  logic                  dout_rdy;
  logic                  dout_last;

  modport slave (
    input  din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld, dout_last
  );

  modport master (
    output din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld, dout_last
  );
endinterface

// File: rtl/sorted_word_serializer.sv
// sorted_word_serializer
//   Captures the sorter's packed 8-word result in one cycle and streams it out
//   one word per accepted beat, flagging the 8th word of each frame.
// Parameters:
//   BITWIDTH - width of one word
//   ASCEND   - 1: smallest first (slice 7 -> 0); 0: largest first (slice 0 -> 7)
// Ports:
//   clk       - rising-edge clock
//   resetn    - asynchronous active-low reset
//   bus       - slave side of the frame-in / word-out handshake bundle
//   frame_cnt - frames fully emitted since reset, wraps 255 -> 0
module sorted_word_serializer #(
  parameter int BITWIDTH = 3,
  parameter int ASCEND   = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  sorted_word_serializer_if.slave     bus,
  output logic [7:0]                  frame_cnt
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [8*BITWIDTH-1:0] frame_q, frame_d;
  logic [BITWIDTH-1:0]   dout_q, dout_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_d;

  logic                  beat_ok;
  logic                  din_rdy_c;
  logic                  capture;
  logic [2:0]            idx_inc;

  // Word emitted at beat position pos, honouring the emit order.
  function automatic logic [BITWIDTH-1:0] word_at(
    input logic [8*BITWIDTH-1:0] frame,
    input logic [2:0]            pos
  );
    logic [2:0] slot;
    slot = (ASCEND != 0) ? (3'd7 - pos) : pos;
    return frame[slot*BITWIDTH +: BITWIDTH];
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      frame_q   <= '0;
      dout_q    <= '0;
      last_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      dout_q    <= dout_d;
      last_q    <= last_d;
      frame_cnt <= cnt_d;
    end
  end

  // dout/dout_last are registered, so the next beat's word is looked up here
  // and loaded at the same edge that advances idx. A capture on the final
  // beat overrides the drop back to IDLE, giving bubble-free back-to-back frames.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    dout_d    = dout_q;
    last_d    = last_q;
    cnt_d     = frame_cnt;

    beat_ok   = (state_q == STREAM) && bus.dout_rdy;
    din_rdy_c = (state_q == IDLE) || (beat_ok && last_q);
    capture   = bus.din_vld && din_rdy_c;
    idx_inc   = idx_q + 3'd1;

    if (beat_ok) begin
      if (last_q) begin
        cnt_d   = frame_cnt + 8'd1;
        state_d = IDLE;
        idx_d   = '0;
        dout_d  = '0;
        last_d  = 1'b0;
      end else begin
        idx_d   = idx_inc;
        dout_d  = word_at(frame_q, idx_inc);
        last_d  = (idx_inc == 3'd7);
      end
    end

    if (capture) begin
      state_d = STREAM;
      idx_d   = '0;
      frame_d = bus.din;
      dout_d  = word_at(bus.din, 3'd0);
      last_d  = 1'b0;
    end
  end

  assign bus.din_rdy   = din_rdy_c;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = (state_q == STREAM);
  assign bus.dout_last = last_q;

endmodule

// File: tb/tb_sorted_word_serializer.sv
// Bench for sorted_word_serializer: one ascending and one descending instance
// share stimulus; a queue-of-beats model predicts every output each cycle.
module tb_sorted_word_serializer;
  localparam int BW = 3;
  localparam int W  = 8 * BW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [W-1:0] din = '0;
  logic din_vld = 1'b0;
  logic dout_rdy = 1'b1;
  logic [7:0] cnt_a, cnt_d;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sorted_word_serializer_if #(.BITWIDTH(BW)) if_a ();
  sorted_word_serializer_if #(.BITWIDTH(BW)) if_d ();

  assign if_a.din = din;      assign if_d.din = din;
  assign if_a.din_vld = din_vld;  assign if_d.din_vld = din_vld;
  assign if_a.dout_rdy = dout_rdy; assign if_d.dout_rdy = dout_rdy;

  sorted_word_serializer #(.BITWIDTH(BW), .ASCEND(1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave), .frame_cnt(cnt_a));
  sorted_word_serializer #(.BITWIDTH(BW), .ASCEND(0)) dut_d (
    .clk(clk), .resetn(resetn), .bus(if_d.slave), .frame_cnt(cnt_d));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: pending beats per instance, in emit order.
  typedef struct { int w; bit last; } beat_t;
  beat_t qa[$];
  beat_t qd[$];
  int mcnt = 0;
  int la[$];   // accepted words (ascending instance)
  int ld[$];   // accepted words (descending instance)
  int lc[$];   // cycle of each accepted beat
  int ll[$];   // dout_last of each accepted beat

  // Consumer ready: 0 always, 1 random, 2 pattern 1,0,0,...
  always begin
    int t;
    @(posedge clk);
    #1;
    t = cyc;
    case (rdy_mode)
      0: dout_rdy = 1'b1;
      1: dout_rdy = 1'($urandom_range(0, 1));
      default: dout_rdy = (t % 3 == 0);
    endcase
  end

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    bit m_rdy, acc;
    logic [W-1:0] f;
    if (!resetn) begin
      qa.delete(); qd.delete(); mcnt = 0;
    end else begin
      m_rdy = (qa.size() == 0) || (qa.size() == 1 && dout_rdy);
      chk("din_rdy_a", int'(if_a.din_rdy), int'(m_rdy));
      chk("din_rdy_d", int'(if_d.din_rdy), int'(m_rdy));
      chk("dout_vld_a", int'(if_a.dout_vld), int'(qa.size() != 0));
      chk("dout_vld_d", int'(if_d.dout_vld), int'(qd.size() != 0));
      chk("frame_cnt_a", int'(cnt_a), mcnt % 256);
      chk("frame_cnt_d", int'(cnt_d), mcnt % 256);
      if (qa.size() != 0) begin
        chk("dout_a", int'(if_a.dout), qa[0].w);
        chk("dout_d", int'(if_d.dout), qd[0].w);
        chk("dout_last_a", int'(if_a.dout_last), int'(qa[0].last));
        chk("dout_last_d", int'(if_d.dout_last), int'(qd[0].last));
      end else begin
        chk("idle_dout_a", int'(if_a.dout), 0);
        chk("idle_dout_d", int'(if_d.dout), 0);
        chk("idle_last_a", int'(if_a.dout_last), 0);
        chk("idle_last_d", int'(if_d.dout_last), 0);
      end
      acc = (qa.size() != 0) && dout_rdy;
      if (acc) begin
        la.push_back(int'(if_a.dout));
        ld.push_back(int'(if_d.dout));
        lc.push_back(cyc);
        ll.push_back(int'(if_a.dout_last));
        if (qa[0].last) mcnt++;
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (din_vld && m_rdy) begin
        f = din;
        for (int k = 0; k < 8; k++) begin
          qa.push_back('{int'(f[(7-k)*BW +: BW]), k == 7});
          qd.push_back('{int'(f[k*BW +: BW]), k == 7});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] f, input bit keep);
    bit got;
    got = 0;
    din = f;
    din_vld = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = if_a.din_rdy;
      step();
    end
    chk("capture", int'(got), 1);
    if (!keep) din_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (qa.size() != 0); i++) step();
    chk("drain_idle", int'(if_a.dout_vld), 0);
  endtask

  task automatic clear_logs();
    la.delete(); ld.delete(); lc.delete(); ll.delete();
  endtask

  initial begin
    logic [W-1:0] spec_frame;
    int ea[8];
    int ed[8];
    int nsent;
    int lastcnt;
    ea = '{0, 1, 2, 3, 3, 5, 6, 7};
    ed = '{7, 6, 5, 3, 3, 2, 1, 0};
    // slices 0..7 = 7,6,5,3,3,2,1,0 (slice 7 in the MSBs)
    spec_frame = {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7};

    // Reset state
    repeat (3) step();
    chk("rst_vld", int'(if_a.dout_vld), 0);
    chk("rst_dout", int'(if_a.dout), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    resetn = 1'b1;
    step();
    chk("rst_din_rdy", int'(if_a.din_rdy), 1);

    // Reference frame, ready held high
    rdy_mode = 0;
    clear_logs();
    send_frame(spec_frame, 0);
    drain();
    chk("spec_beats", la.size(), 8);
    for (int i = 0; i < 8 && i < la.size(); i++) begin
      chk($sformatf("spec_asc_%0d", i), la[i], ea[i]);
      chk($sformatf("spec_desc_%0d", i), ld[i], ed[i]);
      chk($sformatf("spec_last_%0d", i), ll[i], int'(i == 7));
    end
    if (lc.size() == 8) chk("spec_consecutive", lc[7] - lc[0], 7);
    chk("spec_frame_cnt", int'(cnt_a), 1);
    nsent = 1;

    // Backpressure 1,0,0 pattern
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      send_frame(W'($urandom), 1);
      nsent++;
    end
    din_vld = 1'b0;
    drain();

    // Back-to-back with ready high
    rdy_mode = 0;
    clear_logs();
    send_frame(W'($urandom), 1);
    send_frame(W'($urandom), 0);
    nsent += 2;
    drain();
    chk("b2b_beats", la.size(), 16);
    if (lc.size() == 16) chk("b2b_no_bubble", lc[8] - lc[7], 1);

    // All-zero frame
    clear_logs();
    send_frame('0, 0);
    nsent++;
    drain();
    chk("zero_beats", la.size(), 8);
    for (int i = 0; i < 8 && i < la.size(); i++) begin
      chk($sformatf("zero_word_%0d", i), la[i], 0);
      chk($sformatf("zero_last_%0d", i), ll[i], int'(i == 7));
    end

    // Random traffic up to 256 frames -> counter wraps
    rdy_mode = 1;
    while (nsent < 256) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 1)));
      nsent++;
      if (!din_vld) repeat ($urandom_range(0, 3)) step();
    end
    din_vld = 1'b0;
    drain();
    chk("wrap_cnt_a", int'(cnt_a), 0);
    chk("wrap_cnt_d", int'(cnt_d), 0);

    // Reset in the middle of a frame
    rdy_mode = 0;
    send_frame(W'($urandom), 0);
    drain();
    lastcnt = int'(cnt_a);
    chk("post_wrap_cnt", lastcnt, 1);
    send_frame(W'($urandom), 0);
    repeat (2) step();
    #2 resetn = 1'b0;
    #1;
    chk("midrst_vld", int'(if_a.dout_vld), 0);
    chk("midrst_dout", int'(if_a.dout), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    chk("midrst_vld_d", int'(if_d.dout_vld), 0);
    step();
    resetn = 1'b1;
    #1;
    chk("midrst_din_rdy", int'(if_a.din_rdy), 1);
    repeat (6) step();
    chk("midrst_no_beats", int'(if_a.dout_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
